// File: rtl/fechadura_pkg.sv
// rtl/fechadura_pkg.sv - shared lock types, key codes and keypad helpers
// Purpose: digit buffer type, key code constants and keypad decoding helpers
//          used by the lock datapath and the keypad decoder.
// Ports:   none (package).
package fechadura_pkg;

  localparam int NUM_DIGITOS = 20;

  // Index 0 is the newest digit; each element is one 4-bit key code.
  typedef logic [NUM_DIGITOS-1:0][3:0] senhaPac_t;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  // True when exactly one active-low column is pulled down.
  function automatic logic so_um_baixo(input logic [3:0] col);
    logic [3:0] b;
    b = ~col;
    return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
  endfunction

  // Column index of a single low bit; only meaningful when so_um_baixo holds.
  function automatic logic [1:0] indice_coluna(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Rows 0..2 hold 1-9, row 3 holds * 0 #; column 3 (A-D) is ignored.
  function automatic logic [3:0] codigo_tecla(input logic [1:0] lin, input logic [1:0] col);
    logic [3:0] c;
    if (col == 2'd3) begin
      c = KEY_NONE;
    end else if (lin == 2'd3) begin
      c = (col == 2'd0) ? KEY_STAR : ((col == 2'd1) ? 4'h0 : KEY_HASH);
    end else begin
      c = ({2'b00, lin} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/debounce_contador.sv
// rtl/debounce_contador.sv - stability counter with clear and terminal flag
// Purpose: counts consecutive qualifying cycles; terminal rises on the N-th one.
// Ports:   clk, rst (async active-low), clear (priority zero), inc (count one),
//          terminal (count has reached N-1, i.e. this is the N-th stable cycle).
module debounce_contador #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  assign terminal = (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !terminal) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/decodificador_teclado.sv
// rtl/decodificador_teclado.sv - 4x4 keypad scanner, debouncer and digit buffer
// Purpose: scans the keypad rows, debounces one key at a time and shifts the
//          accepted key codes into a 20-digit buffer with a one-cycle valid.
// Ports:   clk, rst (async active-low), enable (scanning enable),
//          col_matriz (active-low columns), lin_matriz (one-hot active-low rows),
//          digitos_value (digit buffer, index 0 newest), digitos_valid (pulse).
module decodificador_teclado
  import fechadura_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} estado_t;

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  estado_t       state, next;
  logic          run;        // enable registered: rows are driven only while set
  logic [1:0]    row;        // also the latched row while debouncing/waiting
  logic [SW-1:0] scan_cnt;
  logic [3:0]    col_lat;
  logic          armed;      // cleared by reset until one full sweep sees no key
  logic          quiet;      // no column activity so far in the current sweep
  logic          limpar_pend;
  logic [IW-1:0] idle_cnt;
  logic          cnt_clr, cnt_inc, cnt_term;
  logic          tecla_ok, fim_linha, coluna_livre;
  logic [3:0]    code_atual;

  assign lin_matriz   = run ? ~(4'b0001 << row) : 4'b1111;
  assign coluna_livre = (col_matriz == 4'b1111);
  assign tecla_ok     = run && armed && so_um_baixo(col_matriz);
  assign fim_linha    = (scan_cnt == SW'(SCAN_DIV - 1));
  assign code_atual   = codigo_tecla(row, indice_coluna(col_lat));

  debounce_contador #(.N(DEBOUNCE_CYCLES)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr),
    .inc      (cnt_inc),
    .terminal (cnt_term)
  );

  always_comb begin
    next    = state;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    case (state)
      SCAN: begin
        if (tecla_ok) next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (col_matriz != col_lat) begin
          next = SCAN;
        end else if (cnt_term) begin
          next = (code_atual == KEY_NONE) ? WAIT_RELEASE : EMIT;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end
      end
      EMIT: next = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (coluna_livre) begin
          if (cnt_term) begin
            next = SCAN;
          end else begin
            cnt_clr = 1'b0;
            cnt_inc = 1'b1;
          end
        end
      end
      default: next = SCAN;
    endcase
    if (!enable) begin
      next    = SCAN;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SCAN;
      run      <= 1'b0;
      row      <= 2'd0;
      scan_cnt <= '0;
      col_lat  <= 4'b1111;
      armed    <= 1'b0;
      quiet    <= 1'b1;
    end else begin
      state <= next;
      run   <= enable;
      if (!enable || !run) begin
        row      <= 2'd0;
        scan_cnt <= '0;
        quiet    <= 1'b1;
      end else if (state == SCAN) begin
        if (tecla_ok) begin
          col_lat <= col_matriz;
        end else if (fim_linha) begin
          scan_cnt <= '0;
          row      <= row + 2'd1;
          if (row == 2'd3) begin
            // A key held across reset keeps the sweep dirty, so it is never
            // accepted until released and pressed again.
            armed <= armed | (quiet && coluna_livre);
            quiet <= 1'b1;
          end else if (!coluna_livre) begin
            quiet <= 1'b0;
          end
        end else begin
          scan_cnt <= scan_cnt + SW'(1);
          if (!coluna_livre) quiet <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digitos_value <= '1;
      digitos_valid <= 1'b0;
      idle_cnt      <= '0;
      limpar_pend   <= 1'b0;
    end else if (!enable) begin
      digitos_value <= '1;
      digitos_valid <= 1'b0;
      idle_cnt      <= '0;
      limpar_pend   <= 1'b0;
    end else begin
      digitos_valid <= (state == EMIT);
      limpar_pend   <= (state == EMIT) && ((code_atual == KEY_STAR) || (code_atual == KEY_HASH));
      if (state == EMIT) begin
        digitos_value <= {digitos_value[NUM_DIGITOS-2:0], code_atual};
        idle_cnt      <= '0;
      end else begin
        if (idle_cnt != IW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + IW'(1);
        if (limpar_pend || ((idle_cnt == IW'(TIMEOUT_CYCLES)) && (digitos_value != '1))) begin
          digitos_value <= '1;
        end
      end
    end
  end

endmodule

// File: doc/decodificador_teclado.md
DECODIFICADOR_TECLADO -- requirements
Module: decodificador_teclado

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each keypad row stays driven during scanning.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a press and to accept a release.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: idle cycles after the last accepted key before the buffer is cleared.
REQ-004 clk  in  1: single system clock; all logic on the rising edge.
REQ-005 rst  in  1: asynchronous, active-low reset.
REQ-006 enable  in  1: scanning enable, driven by the operational block's teclado_en.
REQ-007 col_matriz  in  4: keypad columns, active-low, externally pulled up.
REQ-008 lin_matriz  out  4: keypad row drive, one-hot active-low.
REQ-009 digitos_value  out  senhaPac_t: 20-nibble digit buffer; index 0 holds the newest digit; 0xF marks an empty slot.
REQ-010 digitos_valid  out  1: one-cycle pulse per accepted key.

Function
REQ-011 Key map (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. Digits encode as their value, '*' as 4'hA, '#' as 4'hB. Letters A-D are ignored keys.
REQ-012 FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-013 SCAN: drive the current row low and advance the row every SCAN_DIV cycles, wrapping 3 to 0. Exactly one low column bit latches the row and column and moves to DEBOUNCE.
REQ-014 SCAN with two or more low column bits: treated as no press; scanning continues.
REQ-015 DEBOUNCE: row is held. Any change of col_matriz versus the latched value returns to SCAN and clears the counter. After DEBOUNCE_CYCLES stable cycles, a mapped key goes to EMIT and an ignored key goes straight to WAIT_RELEASE.
REQ-016 EMIT lasts one cycle. On that clock edge:
  - digitos_value shifts left one nibble (index 19 is dropped);
  - the new code enters index 0;
  - digitos_valid is asserted.
  Buffer and valid therefore appear together. The FSM then goes to WAIT_RELEASE.
REQ-017 If the emitted code is 4'hA or 4'hB, the next edge sets digitos_value to all-ones (all nibbles 0xF).
REQ-018 WAIT_RELEASE: row is held; returns to SCAN after col_matriz == 4'b1111 for DEBOUNCE_CYCLES consecutive cycles. Holding a key never produces a repeat.
REQ-019 Idle counter: reset by every EMIT. When it reaches TIMEOUT_CYCLES with the buffer not all-ones, the buffer is set to all-ones. No valid pulse is issued.
REQ-020 enable low:
  - FSM forced to SCAN, row counter to 0;
  - lin_matriz = 4'b1111;
  - digitos_valid = 0;
  - buffer set to all-ones.
  Takes effect on the next edge, including mid-DEBOUNCE and mid-WAIT_RELEASE.
REQ-021 enable rising: scanning restarts at row 0 on the following cycle.
REQ-022 digitos_valid is registered and is never high on two consecutive cycles.

Reset
REQ-023 rst low asynchronously forces:
  - FSM to SCAN; row, debounce and idle counters to 0;
  - lin_matriz = 4'b1111;
  - digitos_value = all-ones;
  - digitos_valid = 0.
REQ-024 Normal operation resumes on the first rising clk edge after rst goes high. A press in progress at reset is discarded.

Structure
REQ-025 senhaPac_t and the key codes (KEY_STAR = 4'hA, KEY_HASH = 4'hB, KEY_NONE = 4'hF) live in the shared fechadura package. The FSM state enum is local.
REQ-026 One sub-module, debounce_contador (stability counter with clear and terminal-count flag), is instantiated once and shared by DEBOUNCE and WAIT_RELEASE.

Verification
REQ-027 Scan and debounce:
  - Press '5' (r1, c1 low while row 1 is driven) held 40 cycles -> exactly one digitos_valid; digitos_value index 0 = 4'h5, all other nibbles 0xF.
  - Press '5' with 3-cycle bounces before the stable hold -> still exactly one valid, no spurious codes.
REQ-028 Sequence '1','2','3','4','*' with releases -> five valid pulses. At the '*' pulse, nibbles [4:0] = 1,2,3,4,A. One cycle later the buffer is all-ones.
REQ-029 Shift overflow:
  - 21 digits '7' -> all 20 nibbles = 7 and index 19 never reads 0xF.
  - Press 'C' -> no valid pulse, buffer unchanged.
REQ-030 Two columns low together (keys 1 and 2) -> no valid. Key '9' held 200 cycles -> one valid only.
REQ-031 Timeout and enable:
  - '8' then TIMEOUT_CYCLES idle -> buffer all-ones, no valid.
  - enable dropped mid-DEBOUNCE -> lin_matriz = 1111 next cycle, no valid.
REQ-032 rst pulsed low between edges during WAIT_RELEASE -> outputs reach reset values immediately. After release of rst, the key still held is not emitted a second time until it is released and pressed again.
